// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight producers/consumers after decode and derives decode stall, per-stage forward selects and the MDU busy interlock
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int NSRC = 2,
  parameter int TW = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SW = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*5-1:0]        id_src_addr,
  input  logic [NSRC*TW-1:0]       id_src_tuse,
  input  logic [4:0]               id_dst_addr,
  input  logic                     id_dst_we,
  input  logic [TW-1:0]            id_tnew,
  input  logic                     id_mdu_req,
  input  logic [1:0]               id_mdu_start,
  input  logic                     flush,
  output logic                     stall,
  output logic [STAGES*NSRC*SW-1:0] fwd_sel,
  output logic                     mdu_busy,
  output logic [15:0]              stall_count
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  logic [STAGES:1] v, we;
  logic [4:0] dst [1:STAGES];
  logic [TW-1:0] tn [1:STAGES];
  logic [4:0] src [1:STAGES-1][0:NSRC-1];
  logic [4:0] cons [0:STAGES-1][0:NSRC-1];
  logic [CW-1:0] cnt;
  logic [SW-1:0] hit;
  logic [TW-1:0] ht;
  logic [4:0] a;
  logic data_stall, issue;
  assign mdu_busy = cnt != '0;
  assign stall = data_stall | (id_mdu_req & mdu_busy);
  assign issue = !stall && !flush;
  always_comb begin
    data_stall = 1'b0;
    fwd_sel = '0;
    hit = '0;
    ht = '0;
    a = '0;
    for (int i = 0; i < NSRC; i++) cons[0][i] = id_src_addr[i*5 +: 5];
    for (int s = 1; s < STAGES; s++)
      for (int i = 0; i < NSRC; i++) cons[s][i] = src[s][i];
    for (int s = 0; s < STAGES; s++)
      for (int i = 0; i < NSRC; i++) begin
        a = cons[s][i];
        hit = '0;
        ht = '0;
        for (int k = STAGES; k >= 1; k--)
          if (k > s && v[k] && we[k] && dst[k] == a && a != '0) begin
            hit = SW'(k);
            ht = tn[k];
          end
        fwd_sel[(s*NSRC+i)*SW +: SW] = (hit != '0 && ht == '0) ? hit : '0;
        if (s == 0 && hit != '0 && ht > id_src_tuse[i*TW +: TW]) data_stall = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v <= '0;
      we <= '0;
      cnt <= '0;
      stall_count <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        dst[k] <= '0;
        tn[k] <= '0;
      end
      for (int k = 1; k < STAGES; k++)
        for (int i = 0; i < NSRC; i++) src[k][i] <= '0;
    end else begin
      v[1] <= issue;
      we[1] <= issue && id_dst_we;
      dst[1] <= issue ? id_dst_addr : '0;
      tn[1] <= issue ? id_tnew : '0;
      for (int i = 0; i < NSRC; i++) src[1][i] <= issue ? id_src_addr[i*5 +: 5] : '0;
      for (int k = 2; k <= STAGES; k++) begin
        v[k] <= v[k-1];
        we[k] <= we[k-1];
        dst[k] <= dst[k-1];
        tn[k] <= tn[k-1] == '0 ? '0 : tn[k-1] - TW'(1);
      end
      for (int k = 2; k < STAGES; k++)
        for (int i = 0; i < NSRC; i++) src[k][i] <= src[k-1][i];
      cnt <= (issue && id_mdu_start == 2'b01) ? CW'(MULT_LAT) :
             (issue && id_mdu_start == 2'b10) ? CW'(DIV_LAT) :
             (cnt != '0) ? cnt - CW'(1) : cnt;
      stall_count <= (stall && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks of hazard_scoreboard against an instruction-history reference model
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [9:0] id_src_addr;
  logic [3:0] id_src_tuse;
  logic [4:0] id_dst_addr;
  logic id_dst_we;
  logic [1:0] id_tnew;
  logic id_mdu_req;
  logic [1:0] id_mdu_start;
  logic flush;
  logic stall, mdu_busy;
  logic [11:0] fwd_sel;
  logic [15:0] stall_count;
  logic [14:0] p_src_addr;
  logic [8:0] p_src_tuse;
  logic [4:0] p_dst_addr;
  logic p_dst_we;
  logic [2:0] p_tnew;
  logic p_stall, p_busy;
  logic [44:0] p_fwd;
  logic [15:0] p_sc;
  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_src_addr(id_src_addr), .id_src_tuse(id_src_tuse),
    .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_tnew(id_tnew), .id_mdu_req(id_mdu_req),
    .id_mdu_start(id_mdu_start), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .mdu_busy(mdu_busy), .stall_count(stall_count)
  );
  hazard_scoreboard #(.STAGES(5), .NSRC(3), .TW(3)) dut5 (
    .clk(clk), .reset(reset), .id_src_addr(p_src_addr), .id_src_tuse(p_src_tuse),
    .id_dst_addr(p_dst_addr), .id_dst_we(p_dst_we), .id_tnew(p_tnew), .id_mdu_req(1'b0),
    .id_mdu_start(2'b00), .flush(1'b0), .stall(p_stall), .fwd_sel(p_fwd),
    .mdu_busy(p_busy), .stall_count(p_sc)
  );
  typedef struct { int t; logic [4:0] dst; bit we; int tn; logic [9:0] src; } ins_t;
  ins_t hist[$];
  int now, mdu_t, mdu_lat, sc, comps, errs, n;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit at_stage(input int k, output ins_t r);
    r = '{0, 5'd0, 1'b0, 0, 10'd0};
    foreach (hist[j]) if (now - hist[j].t + 1 == k) begin
      r = hist[j];
      return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic void youngest(input int s, input logic [4:0] addr, output int kk, output int tn);
    ins_t r;
    kk = 0;
    tn = 0;
    if (addr == 5'd0) return;
    for (int k = s + 1; k <= 3; k++)
      if (at_stage(k, r) && r.we && r.dst == addr) begin
        kk = k;
        tn = r.tn > k - 1 ? r.tn - (k - 1) : 0;
        return;
      end
  endfunction
  function automatic bit busy_exp();
    return mdu_lat > 0 && now - mdu_t < mdu_lat;
  endfunction
  function automatic bit exp_stall();
    int kk, tn;
    bit s;
    s = id_mdu_req && busy_exp();
    for (int i = 0; i < 2; i++) begin
      youngest(0, id_src_addr[i*5 +: 5], kk, tn);
      if (kk != 0 && tn > int'(id_src_tuse[i*2 +: 2])) s = 1'b1;
    end
    return s;
  endfunction
  function automatic logic [11:0] exp_fwd();
    logic [11:0] e;
    logic [4:0] addr;
    ins_t r;
    int kk, tn;
    e = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 2; i++) begin
        if (s == 0) addr = id_src_addr[i*5 +: 5];
        else addr = at_stage(s, r) ? r.src[i*5 +: 5] : 5'd0;
        youngest(s, addr, kk, tn);
        e[(s*2+i)*2 +: 2] = (kk != 0 && tn == 0) ? 2'(kk) : 2'd0;
      end
    return e;
  endfunction
  task automatic check();
    #1;
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("fwd_sel", 32'(fwd_sel), 32'(exp_fwd()));
    chk("mdu_busy", 32'(mdu_busy), 32'(busy_exp()));
    chk("stall_count", 32'(stall_count), 32'(sc));
  endtask
  task automatic tick();
    bit es, iss;
    es = exp_stall();
    iss = !es && !flush;
    if (es && sc < 65535) sc++;
    @(posedge clk);
    now++;
    if (iss) begin
      hist.push_back('{now, id_dst_addr, id_dst_we, int'(id_tnew), id_src_addr});
      if (id_mdu_start == 2'b01) begin mdu_t = now; mdu_lat = 5; end
      else if (id_mdu_start == 2'b10) begin mdu_t = now; mdu_lat = 10; end
    end
    while (hist.size() > 0 && now - hist[0].t + 1 > 3) void'(hist.pop_front());
    #1;
  endtask
  task automatic nop();
    id_src_addr = '0; id_src_tuse = '0; id_dst_addr = '0; id_dst_we = 1'b0; id_tnew = '0;
    id_mdu_req = 1'b0; id_mdu_start = '0; flush = 1'b0;
  endtask
  task automatic rand_d();
    id_src_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    id_src_tuse = 4'($urandom);
    id_dst_addr = 5'($urandom_range(0, 3));
    id_dst_we = 1'($urandom);
    id_tnew = 2'($urandom);
    id_mdu_req = $urandom_range(0, 3) == 0;
    id_mdu_start = $urandom_range(0, 7) == 0 ? 2'($urandom) : 2'b00;
    flush = $urandom_range(0, 7) == 0;
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_fwd"}, 32'(fwd_sel), 32'd0);
    chk({tag, "_busy"}, 32'(mdu_busy), 32'd0);
    chk({tag, "_count"}, 32'(stall_count), 32'd0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    rst_chk("rst");
    @(posedge clk);
    #2;
    rand_d();
    #1;
    rst_chk("rst_rand");
    nop();
    reset = 1'b1;
    hist.delete();
    now = 0;
    mdu_lat = 0;
    sc = 0;
  endtask
  task automatic mdu_run(input logic [1:0] start, input bit fl, input int lat, input string tag);
    do_reset();
    nop(); id_mdu_req = 1'b1; id_mdu_start = start; flush = fl; check(); tick();
    nop(); id_mdu_req = 1'b1;
    chk({tag, "_busy_on"}, 32'(mdu_busy), 32'(lat != 0));
    n = 0;
    for (int c = 0; c < 20; c++) begin
      check();
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(lat));
    chk({tag, "_busy_off"}, 32'(mdu_busy), 32'd0);
    chk({tag, "_count"}, 32'(stall_count), 32'(lat));
    tick();
  endtask
  initial begin
    comps = 0; errs = 0; now = 0; mdu_t = 0; mdu_lat = 0; sc = 0;
    nop();
    p_src_addr = '0; p_src_tuse = '0; p_dst_addr = '0; p_dst_we = 1'b0; p_tnew = '0;
    repeat (3) begin
      @(posedge clk);
      #2;
      rand_d();
      #1;
      rst_chk("hold");
    end
    reset = 1'b1;
    rand_d(); check(); tick();
    do_reset();
    nop(); id_dst_addr = 5'd2; id_dst_we = 1'b1; id_tnew = 2'd2; check(); tick();
    nop(); id_src_addr = {5'd2, 5'd2}; id_src_tuse = 4'b0101; id_dst_addr = 5'd3; id_dst_we = 1'b1; id_tnew = 2'd1;
    check(); chk("lu_stall1", 32'(stall), 32'd1); tick();
    check(); chk("lu_stall2", 32'(stall), 32'd0); tick();
    nop(); check();
    chk("lu_fwd_e", 32'(fwd_sel[7:4]), 32'hF);
    chk("lu_count", 32'(stall_count), 32'd1);
    tick();
    do_reset();
    nop(); id_dst_addr = 5'd4; id_dst_we = 1'b1; id_tnew = 2'd1; check(); tick(); check(); tick();
    nop(); id_src_addr = 10'd4; check();
    chk("yw_stall", 32'(stall), 32'd1);
    chk("yw_fwd_d", 32'(fwd_sel[1:0]), 32'd0);
    tick(); check();
    chk("yw_stall_clear", 32'(stall), 32'd0);
    chk("yw_fwd_d2", 32'(fwd_sel[1:0]), 32'd2);
    tick();
    nop(); id_dst_we = 1'b1; id_tnew = 2'd2; check(); tick();
    nop(); check();
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fwd", 32'(fwd_sel[3:0]), 32'd0);
    tick();
    mdu_run(2'b01, 1'b0, 5, "mult");
    mdu_run(2'b10, 1'b0, 10, "div");
    mdu_run(2'b01, 1'b1, 0, "flush");
    do_reset();
    nop(); id_mdu_req = 1'b1; id_mdu_start = 2'b01; check(); tick();
    nop(); check(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", 32'(mdu_busy), 32'd0);
    do_reset();
    repeat (400) begin rand_d(); check(); tick(); end
    do_reset();
    p_dst_addr = 5'd7; p_dst_we = 1'b1; p_tnew = 3'd4;
    #1;
    chk("p_issue_stall", 32'(p_stall), 32'd0);
    @(posedge clk); #1;
    p_dst_addr = '0; p_dst_we = 1'b0; p_tnew = '0; p_src_addr = {5'd7, 10'd0}; p_src_tuse = {3'd1, 6'd0};
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (p_stall !== 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
    chk("p_stall_cycles", 32'(n), 32'd3);
    chk("p_fwd_d", 32'(p_fwd[8:6]), 32'd0);
    @(posedge clk); #1;
    p_src_addr = '0; p_src_tuse = '0;
    #1;
    chk("p_fwd_e", 32'(p_fwd[17:15]), 32'd5);
    chk("p_count", 32'(p_sc), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding scoreboard for the multi-stage MIPS pipeline. The decode stage presents each instruction's source registers, their Tuse values, its destination and its Tnew. The block tracks in-flight destinations and sources through STAGES pipeline stages after decode. It produces the decode stall, per-stage per-operand forward selects, and an internal multiply/divide busy interlock. It is a superset of the fixed 3-stage/2-operand controller: depth, operand count, timing width and MDU latencies are parameters, and MDU busy is generated internally.

## Interface
- STAGES, 3: stages after D that carry a destination (1=E … STAGES=W).
- NSRC, 2: source operands per instruction.
- TW, 2: width of Tuse/Tnew fields.
- MULT_LAT, 5: busy cycles for a multiply.
- DIV_LAT, 10: busy cycles for a divide.
- Derived: SW = $clog2(STAGES+1).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_src_addr  in  NSRC*5  D-stage source registers; operand i at [i*5 +: 5].
- id_src_tuse  in  NSRC*TW  Tuse per operand.
- id_dst_addr  in  5  D-stage destination register.
- id_dst_we  in  1  D-stage instruction writes its destination.
- id_tnew  in  TW  Tnew the instruction will have on entering E.
- id_mdu_req  in  1  D-stage instruction uses MDU/HI/LO.
- id_mdu_start  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none).
- flush  in  1  insert a bubble into E this cycle.
- stall  out  1  hold F/D and insert a bubble into E.
- fwd_sel  out  STAGES*NSRC*SW  consumer stage s (0=D … STAGES-1), operand i at [(s*NSRC+i)*SW +: SW]. 0 = register file/no forward; k = forward from stage k.
- mdu_busy  out  1  MDU countdown is non-zero.
- stall_count  out  16  saturating count of stalled cycles.

## Operation
- Each stage k holds: valid, dst, we, tnew, and NSRC source addresses.
- On every edge, stage k+1 takes stage k, and stage STAGES is discarded.
- Stage 1 (E) loads the D instruction when stall=0 and flush=0. Otherwise it loads a bubble (valid=0, we=0, tnew=0).
- Tnew: the value loaded into E is id_tnew. Each subsequent advance decrements it, saturating at 0.
- A producer at stage k matches address a when valid, we, dst==a, and a!=0.
- The youngest (smallest k) matching producer wins; older matches are ignored.
- Data stall: for some D operand i, the youngest match at k>=1 has tnew > tuse_i.
- MDU stall: id_mdu_req and the countdown is non-zero.
- stall = data stall OR MDU stall. It is purely combinational from state and D inputs.
- Forwarding for consumer stage s, operand i, with source address a:
  - fwd_sel = smallest k>s whose producer matches a and has tnew==0.
  - If the youngest match has tnew!=0, fwd_sel = 0, because that operand is stalled or not yet needed.
  - Address 0 always gives 0.
- MDU countdown:
  - When the D instruction enters E with id_mdu_start 01, load MULT_LAT. With 10, load DIV_LAT.
  - Otherwise decrement if non-zero.
  - A load overrides a decrement.
- stall_count increments on each cycle with stall=1 and holds at 16'hFFFF.

## Timing
- Reset (reset=0, asynchronous) clears:
  - all stage valid/we/tnew/addresses to 0;
  - the countdown to 0;
  - stall_count to 0.
- As a result stall=0, fwd_sel=0 and mdu_busy=0 while reset is held and on the first cycle after release.
- Zero-latency outputs: stall and fwd_sel follow D inputs and state within the same cycle.
- A multiply issued at edge t makes mdu_busy=1 during cycles t..t+MULT_LAT-1. It is 0 from t+MULT_LAT.
- A dependent mfhi is stalled for exactly MULT_LAT cycles.
- A flush or stall in the same cycle as id_mdu_start does not load the countdown, since the instruction did not issue.
- A reset asserted mid-countdown clears the countdown immediately.
- stall and flush together insert a single bubble.

## Test plan
- Reset: hold reset=0 with random D inputs.
  - Required: stall=0, fwd_sel=0, mdu_busy=0, stall_count=0.
- Load-use: issue lw $2 (tnew=2), then add $3,$2,$2 (tuse=1,1).
  - Cycle with lw in E: stall=1 for exactly one cycle.
  - Next cycle (lw in M, tnew=1): stall=0.
  - When add is in E: E-stage fwd_sel for both operands = 3 (W).
  - stall_count = 1.
- Youngest wins: addu $4 (tnew=1) issued twice back-to-back.
  - Consumer with tuse=0 in D stalls on the younger producer in E.
  - The consumer must never select the older producer.
- Register 0: producer writes $0 with tnew=2, consumer reads $0 with tuse=0.
  - Required: stall=0, fwd_sel=0.
- MDU: issue mult, then mfhi (mdu_req=1) immediately behind it.
  - Required: stall=1 for 5 cycles, mdu_busy falls after 5 cycles.
  - Repeat with div: stall=1 for 10 cycles.
  - Repeat with flush asserted at the mult issue: no busy.
- Parameters: STAGES=5, NSRC=3, TW=3.
  - Producer tnew=4, consumer operand 2 with tuse=1.
  - Required: stall for 3 cycles, then forward from stage 5 once its tnew reaches 0.
